// File: rtl/rot_pkg.sv
// Shared definitions for the rotator: default width, direction enum and a
// behavioural rotate reference used by the optional self-checks.
package rot_pkg;

   localparam int ROT_DEFAULT_N = 4;
   localparam int ROT_MAX_W     = 32;

   typedef enum logic {
      ROT_LEFT  = 1'b0,
      ROT_RIGHT = 1'b1
   } rot_dir_e;

   // Rotates the low n bits of data; bits at and above n are returned as zero.
   function automatic logic [ROT_MAX_W-1:0] rot_ref(
      input logic [ROT_MAX_W-1:0] data,
      input int unsigned          amt,
      input rot_dir_e             dir,
      input int unsigned          n = ROT_DEFAULT_N
   );
      logic [ROT_MAX_W-1:0] res;
      int unsigned          src;
      res = '0;
      for (int unsigned i = 0; i < n; i++) begin
         if (dir == ROT_LEFT) src = (i + n - (amt % n)) % n;
         else                 src = (i + amt) % n;
         res[i] = data[src];
      end
      return res;
   endfunction

endpackage

// File: rtl/rot_barrel.sv
// One direction of the log2(N)-stage barrel rotator; stage s rotates by 2**s
// when rotamt[s] is set.
module rot_barrel
   import rot_pkg::*;
#(
   parameter int       N   = ROT_DEFAULT_N,
   parameter rot_dir_e DIR = ROT_LEFT,
   parameter int       RW  = $clog2(N)
) (
   input  logic [N-1:0]  data_i,
   input  logic [RW-1:0] amt_i,
   output logic [N-1:0]  data_o
);

   logic [N-1:0] stage_d;
   logic [N-1:0] rot_d;

   // The ternary (not an if) lets an unknown amt bit turn differing bits to X.
   always_comb begin
      stage_d = data_i;
      rot_d   = '0;
      for (int s = 0; s < RW; s++) begin
         if (DIR == ROT_LEFT) rot_d = (stage_d << (1 << s)) | (stage_d >> (N - (1 << s)));
         else                 rot_d = (stage_d >> (1 << s)) | (stage_d << (N - (1 << s)));
         stage_d = amt_i[s] ? rot_d : stage_d;
      end
      data_o = stage_d;
   end

endmodule

// File: rtl/four_bit_rot.sv
// Left/right rotator with combinational results and a one-cycle registered copy.
// Optional simulation self-checks are compiled when ROT_SELFCHECK_EN is defined.
module four_bit_rot
   import rot_pkg::*;
#(
   parameter int N  = ROT_DEFAULT_N,
   parameter int RW = $clog2(N)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [N-1:0]  A,
   input  logic [RW-1:0] rotamt,
   input  logic          in_valid,
   output logic [N-1:0]  Yleft,
   output logic [N-1:0]  Yright,
   output logic [N-1:0]  Yleft_q,
   output logic [N-1:0]  Yright_q,
   output logic          out_valid
);

   logic [N-1:0] yleft_d;
   logic [N-1:0] yright_d;

   rot_barrel #(.N(N), .DIR(ROT_LEFT), .RW(RW)) u_left (
      .data_i (A),
      .amt_i  (rotamt),
      .data_o (yleft_d)
   );

   rot_barrel #(.N(N), .DIR(ROT_RIGHT), .RW(RW)) u_right (
      .data_i (A),
      .amt_i  (rotamt),
      .data_o (yright_d)
   );

   assign Yleft  = yleft_d;
   assign Yright = yright_d;

   // Valid-only handshake: no ready/backpressure; data registers load every cycle
   // and in_valid is simply delayed one cycle so consumers qualify with out_valid.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         Yleft_q   <= '0;
         Yright_q  <= '0;
         out_valid <= 1'b0;
      end else begin
         Yleft_q   <= yleft_d;
         Yright_q  <= yright_d;
         out_valid <= in_valid;
      end
   end

`ifdef ROT_SELFCHECK_EN
   logic [ROT_MAX_W-1:0] a_ext;
   logic [ROT_MAX_W-1:0] yl_ext;

   always_comb begin
      a_ext          = '0;
      a_ext[N-1:0]   = A;
      yl_ext         = '0;
      yl_ext[N-1:0]  = yleft_d;
      if (!$isunknown({A, rotamt})) begin
         assert (yl_ext == rot_ref(a_ext, (N - int'(rotamt)) % N, ROT_RIGHT, N))
            else $error("rot left/right identity broken: A=%0h rotamt=%0d", A, rotamt);
         assert (rot_ref(yl_ext, int'(rotamt), ROT_RIGHT, N) == a_ext)
            else $error("rot round trip broken: A=%0h rotamt=%0d", A, rotamt);
      end
   end
`endif

endmodule

// File: tb/tb_four_bit_rot.sv
// Directed and sweep bench for four_bit_rot (N=4): combinational results,
// registered copies with valid, and asynchronous reset behaviour.
module tb_four_bit_rot;
   import rot_pkg::*;

   localparam int N  = 4;
   localparam int RW = 2;

   logic          clk;
   logic          rst;
   logic [N-1:0]  A;
   logic [RW-1:0] rotamt;
   logic          in_valid;
   logic [N-1:0]  Yleft, Yright, Yleft_q, Yright_q;
   logic          out_valid;

   int n_checks = 0;
   int n_pass   = 0;

   // Expected registered result: {yleft, yright, valid}
   logic [2*N:0] exp_q[$];

   four_bit_rot #(.N(N)) dut (
      .clk       (clk),
      .rst       (rst),
      .A         (A),
      .rotamt    (rotamt),
      .in_valid  (in_valid),
      .Yleft     (Yleft),
      .Yright    (Yright),
      .Yleft_q   (Yleft_q),
      .Yright_q  (Yright_q),
      .out_valid (out_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %b expected %b", tag, got, exp);
   endtask

   function automatic logic [N-1:0] ref_rot(input logic [N-1:0] a, input int amt, input rot_dir_e d);
      logic [ROT_MAX_W-1:0] ext;
      logic [ROT_MAX_W-1:0] res;
      ext = '0;
      ext[N-1:0] = a;
      res = rot_ref(ext, amt, d, N);
      return res[N-1:0];
   endfunction

   task automatic drive(input logic [N-1:0] a, input logic [RW-1:0] amt, input logic iv);
      A        = a;
      rotamt   = amt;
      in_valid = iv;
   endtask

   logic [N-1:0]  dir_l [4] = '{4'b0110, 4'b1100, 4'b1001, 4'b0011};
   logic [N-1:0]  dir_r [4] = '{4'b0110, 4'b0011, 4'b1001, 4'b1100};
   logic [2*N:0]  exp_v;
   logic [N-1:0]  el, er;
   logic          iv;

   initial begin
      rst = 1'b1;
      drive(4'b0000, 2'd0, 1'b0);
      #2;
      check("reset_yleft_q",   Yleft_q,   4'b0000);
      check("reset_yright_q",  Yright_q,  4'b0000);
      check("reset_out_valid", 4'(out_valid), 4'b0000);

      @(negedge clk);
      rst = 1'b0;

      // Directed vectors on A=0110 for every rotate amount.
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         drive(4'b0110, RW'(k), 1'b1);
         #1;
         check($sformatf("dir_yleft_k%0d", k),  Yleft,  dir_l[k]);
         check($sformatf("dir_yright_k%0d", k), Yright, dir_r[k]);
         @(posedge clk);
         #1;
         check($sformatf("dir_yleft_q_k%0d", k),  Yleft_q,  dir_l[k]);
         check($sformatf("dir_yright_q_k%0d", k), Yright_q, dir_r[k]);
         check($sformatf("dir_valid_k%0d", k),    4'(out_valid), 4'b0001);
      end

      // Exhaustive sweep with randomly toggling in_valid.
      for (int a = 0; a < 16; a++) begin
         for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            iv = 1'($urandom_range(0, 1));
            drive(N'(a), RW'(k), iv);
            el = ref_rot(N'(a), k, ROT_LEFT);
            er = ref_rot(N'(a), k, ROT_RIGHT);
            #1;
            check("sweep_yleft",  Yleft,  el);
            check("sweep_yright", Yright, er);
            exp_q.push_back({el, er, iv});
            @(posedge clk);
            #1;
            exp_v = exp_q.pop_front();
            check("sweep_yleft_q",  Yleft_q,  exp_v[2*N:N+1]);
            check("sweep_yright_q", Yright_q, exp_v[N:1]);
            check("sweep_valid",    4'(out_valid), 4'(exp_v[0]));
         end
      end

      // Asynchronous reset between edges while out_valid is high.
      @(negedge clk);
      drive(4'b0110, 2'd1, 1'b1);
      @(posedge clk);
      #1;
      check("pre_rst_valid", 4'(out_valid), 4'b0001);
      #1;
      rst = 1'b1;
      #1;
      check("async_rst_yleft_q",  Yleft_q,  4'b0000);
      check("async_rst_yright_q", Yright_q, 4'b0000);
      check("async_rst_valid",    4'(out_valid), 4'b0000);
      check("rst_comb_yleft",  Yleft,  4'b1100);
      check("rst_comb_yright", Yright, 4'b0011);
      drive(4'b1010, 2'd1, 1'b1);
      #1;
      check("rst_track_yleft",  Yleft,  4'b0101);
      check("rst_track_yright", Yright, 4'b0101);
      @(negedge clk);
      rst = 1'b0;
      drive(4'b0001, 2'd3, 1'b0);
      @(posedge clk);
      #1;
      check("post_rst_yleft_q",  Yleft_q,  4'b1000);
      check("post_rst_yright_q", Yright_q, 4'b0010);
      check("post_rst_valid",    4'(out_valid), 4'b0000);
      @(negedge clk);
      drive(4'b0011, 2'd2, 1'b1);
      @(posedge clk);
      #1;
      check("recapture_yleft_q",  Yleft_q,  4'b1100);
      check("recapture_yright_q", Yright_q, 4'b1100);
      check("recapture_valid",    4'(out_valid), 4'b0001);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
